// File: rtl/imm_assembler_pkg.sv
// Shared types and default widths for the immediate assembler.
package imm_assembler_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_CHUNK_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } imm_state_t;

endpackage

// File: rtl/imm_assembler_extender.sv
// Widens a narrow field to OUTPUT_WIDTH, replicating the top bit when
// is_sign_ext is set and filling with zeros otherwise.
module imm_assembler_extender #(
  parameter int INPUT_WIDTH  = 4,
  parameter int OUTPUT_WIDTH = 8
) (
  input  logic [INPUT_WIDTH-1:0]  value,
  input  logic                    is_sign_ext,
  output logic [OUTPUT_WIDTH-1:0] extended
);

  logic fill;

  assign fill = is_sign_ext & value[INPUT_WIDTH-1];

  always_comb begin
    extended                    = {OUTPUT_WIDTH{fill}};
    extended[INPUT_WIDTH-1:0]   = value;
  end

endmodule

// File: rtl/imm_assembler.sv
// Assembles a DATA_WIDTH immediate from MSB-first CHUNK_WIDTH chunks.
// Optional feature: define IMM_OVERFLOW_DETECT_EN to report chunk overflow.
module imm_assembler
  import imm_assembler_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chunk_valid,
  output logic                   chunk_ready,
  input  logic [CHUNK_WIDTH-1:0] chunk_data,
  input  logic                   chunk_last,
  input  logic                   chunk_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_val,
  output logic                   out_overflow
);

  localparam int MAX_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_CHUNKS + 1);

  imm_state_t            state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] first_val;
  logic [CNT_W-1:0]      cnt;
`ifdef IMM_OVERFLOW_DETECT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHUNKS);
  logic                  ovf;
`endif

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + 1'b1;
  endfunction

  imm_assembler_extender #(
    .INPUT_WIDTH (CHUNK_WIDTH),
    .OUTPUT_WIDTH(DATA_WIDTH)
  ) u_extender (
    .value      (chunk_data),
    .is_sign_ext(chunk_signed),
    .extended   (first_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      chunk_ready <= 1'b1;
      out_valid   <= 1'b0;
`ifdef IMM_OVERFLOW_DETECT_EN
      ovf         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (chunk_valid) begin
            if (state == IDLE) begin
              acc <= first_val;
              cnt <= CNT_W'(1);
            end else begin
              // Older bits fall off the top; only the low DATA_WIDTH bits survive.
              acc <= (acc << CHUNK_WIDTH) | DATA_WIDTH'(chunk_data);
              cnt <= cnt_sat_inc(cnt);
`ifdef IMM_OVERFLOW_DETECT_EN
              if (cnt >= CNT_MAX) ovf <= 1'b1;
`endif
            end
            if (chunk_last) begin
              state       <= HOLD;
              chunk_ready <= 1'b0;
              out_valid   <= 1'b1;
            end else begin
              state       <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state       <= IDLE;
            cnt         <= '0;
            chunk_ready <= 1'b1;
            out_valid   <= 1'b0;
`ifdef IMM_OVERFLOW_DETECT_EN
            ovf         <= 1'b0;
`endif
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          chunk_ready <= 1'b1;
          out_valid   <= 1'b0;
`ifdef IMM_OVERFLOW_DETECT_EN
          ovf         <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign out_val = acc;

`ifdef IMM_OVERFLOW_DETECT_EN
  assign out_overflow = ovf;
`else
  assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_imm_assembler.sv
// Directed and randomized bench for imm_assembler (DATA_WIDTH=8, CHUNK_WIDTH=4)
// against an arithmetic reference model of the chunk assembly rules.
module tb_imm_assembler;

  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int MAXC = DW / CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          chunk_valid;
  logic          chunk_ready;
  logic [CW-1:0] chunk_data;
  logic          chunk_last;
  logic          chunk_signed;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_val;
  logic          out_overflow;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] last_result;

  always #5 clk = ~clk;

  imm_assembler #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk_data  (chunk_data),
    .chunk_last  (chunk_last),
    .chunk_signed(chunk_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_val     (out_val),
    .out_overflow(out_overflow)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of the first n chunks: first one as a signed/unsigned integer,
  // each later chunk appended as a base-2^CW digit, kept modulo 2^DW.
  function automatic logic [DW-1:0] model_val(input int n, input logic [CW-1:0] c[4], input bit sgn);
    int v;
    v = int'(c[0]);
    if (sgn && v >= (1 << (CW - 1))) v = v - (1 << CW);
    for (int i = 1; i < n; i++) v = v * (1 << CW) + int'(c[i]);
    return DW'(v);
  endfunction

  function automatic bit model_ovf(input int n);
`ifdef IMM_OVERFLOW_DETECT_EN
    return n > MAXC;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_gap(input int cycles, input logic [DW-1:0] exp_acc);
    for (int k = 0; k < cycles; k++) begin
      chunk_valid  = 1'b0;
      chunk_data   = CW'($urandom);
      chunk_last   = 1'($urandom);
      chunk_signed = 1'($urandom);
      @(posedge clk); #1;
      check("gap_out_valid", out_valid, 0);
      check("gap_chunk_ready", chunk_ready, 1);
      check("gap_acc_stable", out_val, exp_acc);
    end
  endtask

  task automatic run_imm(input int n, input logic [CW-1:0] c[4], input bit sgn, input int hold,
                         input logic [DW-1:0] exp_val, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle_gap(int'($urandom_range(0, 2)), (i == 0) ? last_result : model_val(i, c, sgn));
      chunk_valid  = 1'b1;
      chunk_data   = c[i];
      chunk_last   = (i == n - 1);
      chunk_signed = (i == 0) ? sgn : 1'($urandom);
      check("accept_ready", chunk_ready, 1);
      @(posedge clk); #1;
      chunk_valid = 1'b0;
    end
    check("result_valid", out_valid, 1);
    check("result_val", out_val, exp_val);
    check("result_ovf", out_overflow, model_ovf(n));
    check("hold_ready", chunk_ready, 0);
    for (int k = 0; k < hold; k++) begin
      out_ready   = 1'b0;
      chunk_valid = 1'($urandom);
      chunk_data  = CW'($urandom);
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_val", out_val, exp_val);
      check("bp_ready", chunk_ready, 0);
    end
    out_ready   = 1'b1;
    chunk_valid = 1'b1;
    chunk_data  = CW'($urandom);
    chunk_last  = 1'b1;
    @(posedge clk); #1;
    out_ready   = 1'b0;
    chunk_valid = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_ready", chunk_ready, 1);
    check("drain_ovf", out_overflow, 0);
    check("drain_acc", out_val, exp_val);
    last_result = exp_val;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [CW-1:0] ch [4];
    int n;
    bit sgn;

    reset        = 1'b1;
    chunk_valid  = 1'b0;
    chunk_data   = '0;
    chunk_last   = 1'b0;
    chunk_signed = 1'b0;
    out_ready    = 1'b0;
    last_result  = '0;
    #1;
    check("rst_ready", chunk_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_val", out_val, 0);
    check("rst_ovf", out_overflow, 0);
    #11 reset = 1'b0;
    @(posedge clk); #1;

    ch = '{4'hA, 4'h0, 4'h0, 4'h0};
    run_imm(1, ch, 1'b1, 0, 8'hFA, 1'b0);
    run_imm(1, ch, 1'b0, 0, 8'h0A, 1'b0);
    ch = '{4'h8, 4'h1, 4'h0, 4'h0};
    run_imm(2, ch, 1'b1, 0, 8'h81, 1'b0);
    ch = '{4'h1, 4'h2, 4'h3, 4'h0};
    run_imm(3, ch, 1'b0, 3, 8'h23, 1'b0);

    // Reset pulse while an immediate is half assembled.
    chunk_valid  = 1'b1;
    chunk_data   = 4'h8;
    chunk_last   = 1'b0;
    chunk_signed = 1'b1;
    @(posedge clk); #1;
    chunk_valid = 1'b0;
    check("mid_partial", out_val, 8'hF8);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", chunk_ready, 1);
    check("mid_rst_val", out_val, 0);
    #1 reset = 1'b0;
    last_result = '0;
    @(posedge clk); #1;
    ch = '{4'h3, 4'h0, 4'h0, 4'h0};
    run_imm(1, ch, 1'b0, 1, 8'h03, 1'b0);

    for (int t = 0; t < 25; t++) begin
      n   = int'($urandom_range(1, 4));
      sgn = 1'($urandom);
      for (int i = 0; i < 4; i++) ch[i] = CW'($urandom);
      run_imm(n, ch, sgn, int'($urandom_range(0, 3)), model_val(n, ch, sgn), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_assembler.md
IMM_ASSEMBLER -- requirements
Module: imm_assembler

Interface
REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the width of the assembled immediate.
REQ-002: Parameter CHUNK_WIDTH, default 4, SHALL set the width of one instruction immediate chunk, with 1 <= CHUNK_WIDTH <= DATA_WIDTH.
REQ-003: clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004: reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005: chunk_valid  input  1  SHALL mark chunk_data, chunk_last and chunk_signed as valid.
REQ-006: chunk_ready  output  1  SHALL mark that the block accepts a chunk this cycle.
REQ-007: chunk_data  input  CHUNK_WIDTH  SHALL carry the immediate chunk, most significant chunk first.
REQ-008: chunk_last  input  1  SHALL mark the final chunk of an immediate.
REQ-009: chunk_signed  input  1  SHALL request sign extension; it is meaningful only on the first chunk.
REQ-010: out_valid  output  1  SHALL mark that out_val holds a completed immediate.
REQ-011: out_ready  input  1  SHALL indicate that the downstream stage consumes out_val.
REQ-012: out_val  output  DATA_WIDTH  SHALL carry the assembled, extended immediate.
REQ-013: out_overflow  output  1  SHALL flag that the assembled chunks exceeded DATA_WIDTH bits.

Function
REQ-014: A chunk SHALL be accepted when chunk_valid and chunk_ready are both 1 in the same cycle.
REQ-015: The FSM SHALL have three states:
- IDLE: no chunk held.
- ACCUM: at least one chunk held, last chunk not yet seen.
- HOLD: result presented on out_val.
REQ-016: chunk_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-017: In IDLE, an accepted chunk SHALL load acc with chunk_data extended to DATA_WIDTH, sign-extended when chunk_signed=1 and zero-extended when chunk_signed=0.
REQ-018: In ACCUM, an accepted chunk SHALL update acc to {acc[DATA_WIDTH-CHUNK_WIDTH-1:0], chunk_data}, discarding the shifted-out bits.
REQ-019: State transitions on an accepted chunk SHALL be:
- chunk_last=1: to HOLD.
- chunk_last=0: to ACCUM.
- First chunk with chunk_last=1: IDLE to HOLD directly.
REQ-020: Latency SHALL be one cycle: out_valid=1 in the cycle after the last chunk is accepted.
REQ-021: out_valid SHALL equal (state==HOLD); out_val SHALL equal acc and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022: In HOLD with out_ready=1, the FSM SHALL return to IDLE on the next edge; no chunk is accepted in that cycle.
REQ-023: A chunk counter SHALL count accepted chunks of the current immediate, saturate at DATA_WIDTH/CHUNK_WIDTH+1, and clear on entry to IDLE.
REQ-024: When the counter would exceed DATA_WIDTH/CHUNK_WIDTH (integer division), an overflow flag SHALL be set and held until the next return to IDLE.
REQ-025: chunk_valid=0 in IDLE or ACCUM SHALL leave all state unchanged.

Reset
REQ-026: On reset asserted, state SHALL go to IDLE and acc, the counter and the overflow flag SHALL clear to 0 immediately, independent of clk.
REQ-027: Reset values SHALL be chunk_ready=1, out_valid=0, out_val=0, out_overflow=0.
REQ-028: A reset mid-immediate SHALL discard the partial immediate, and the next accepted chunk SHALL be treated as a first chunk.

Configuration
REQ-029: With IMM_OVERFLOW_DETECT_EN defined, out_overflow SHALL reflect the overflow flag (REQ-024).
REQ-030: Without IMM_OVERFLOW_DETECT_EN, the overflow flag and the counter's overflow compare SHALL be omitted, out_overflow SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Structure
REQ-031: The FSM state enum (IDLE, ACCUM, HOLD) SHALL be defined in the shared package.
REQ-032: The default DATA_WIDTH and CHUNK_WIDTH constants SHALL be defined in the shared package.
REQ-033: First-chunk extension SHALL use one instance of the existing extender sub-module, with INPUT_WIDTH=CHUNK_WIDTH and is_sign_ext=chunk_signed.

Verification (DATA_WIDTH=8, CHUNK_WIDTH=4)
REQ-034: Single signed chunk: 4'hA with last=1, signed=1 -> out_val=8'hFA and out_valid=1 the next cycle, out_overflow=0.
REQ-035: Single unsigned chunk: 4'hA with last=1, signed=0 -> out_val=8'h0A.
REQ-036: Two signed chunks: 4'h8 then 4'h1 (last) -> out_val=8'h81, out_overflow=0.
REQ-037: Three chunks: 4'h1, 4'h2, 4'h3 (last) -> out_val=8'h23, with out_overflow=1 when IMM_OVERFLOW_DETECT_EN is defined and 0 when it is not.
REQ-038: Backpressure: out_ready=0 for 3 cycles in HOLD -> out_val stable and chunk_ready=0 throughout; then out_ready=1 -> IDLE and chunk_ready=1 the next cycle.
REQ-039: Reset mid-immediate: reset pulsed after accepting 4'h8 (last=0) -> out_valid=0 and state IDLE; next chunk 4'h3 (last=1, signed=0) -> out_val=8'h03.
